led_blink_multi: RTL

- Parametrised multi-channel successor to the single-LED blinker. Drives CH LEDs, each with its own 2-bit mode (off / on / blink / burst) and 2-bit rate select.
- A shared prescaler generates a base tick. Each channel runs a small FSM off that tick.
- A sync input phase-aligns all channels.
- Sits between board switches or a control register and the LED pins.

---
 rtl/led_blink_pkg.sv | 18 +
 rtl/led_chan_fsm.sv | 117 +++++++++++
 rtl/led_blink_multi.sv | 55 +++++
 3 files changed

// File: rtl/led_blink_pkg.sv
// Shared encodings for the multi-channel LED blinker.
package led_blink_pkg;

   // Per-channel mode field encodings
   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   // Channel FSM states: idle, flash on, flash off, inter-burst gap
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FON  = 2'b01,
      ST_FOFF = 2'b10,
      ST_GAP  = 2'b11
   } chan_state_e;

endpackage

// File: rtl/led_chan_fsm.sv
// One LED channel: mode tracking, phase/flash counters and registered LED drive.
module led_chan_fsm
   import led_blink_pkg::*;
#(
   parameter int unsigned HALF_BASE  = 500,
   parameter int unsigned BURST_N    = 3,
   parameter int unsigned GAP_HALVES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       sync,
   input  logic [1:0] mode,
   input  logic [1:0] rate,
   output logic       led
);

   localparam int unsigned PW = $clog2(HALF_BASE * GAP_HALVES);
   localparam int unsigned FW = $clog2(BURST_N + 1);

   chan_state_e   state, state_n;
   logic [PW-1:0] pc, pc_n;
   logic [FW-1:0] fc, fc_n, fc_inc;
   logic [1:0]    mode_q;
   logic          led_n;
   logic          half_end, gap_end;
   int unsigned   half;

   // State, counters, stored mode and LED flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         pc     <= '0;
         fc     <= '0;
         mode_q <= MODE_OFF;
         led    <= 1'b0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         fc     <= fc_n;
         mode_q <= mode;
         led    <= led_n;
      end
   end

   // Next-state: sync beats mode change beats tick; half-period follows live rate
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      fc_n     = fc;
      led_n    = led;
      half     = HALF_BASE >> rate;
      half_end = (32'(pc) >= half - 32'd1);
      gap_end  = (32'(pc) >= GAP_HALVES * half - 32'd1);
      fc_inc   = fc + FW'(1);

      if (sync) begin
         state_n = ST_IDLE;
         pc_n    = '0;
         fc_n    = '0;
         led_n   = 1'b0;
      end else if (mode != mode_q || mode == MODE_OFF || mode == MODE_ON) begin
         state_n = ST_IDLE;
         pc_n    = '0;
         fc_n    = '0;
         led_n   = (mode == MODE_ON);
      end else if (tick) begin
         case (state)
            ST_IDLE: begin
               state_n = ST_FON;
               pc_n    = '0;
               led_n   = 1'b1;
            end
            ST_FON: begin
               if (half_end) begin
                  pc_n  = '0;
                  led_n = 1'b0;
                  if (mode == MODE_BURST) begin
                     fc_n    = fc_inc;
                     state_n = (32'(fc_inc) == BURST_N) ? ST_GAP : ST_FOFF;
                  end else begin
                     state_n = ST_FOFF;
                  end
               end else begin
                  pc_n = pc + PW'(1);
               end
            end
            ST_FOFF: begin
               if (half_end) begin
                  state_n = ST_FON;
                  pc_n    = '0;
                  led_n   = 1'b1;
               end else begin
                  pc_n = pc + PW'(1);
               end
            end
            ST_GAP: begin
               if (gap_end) begin
                  state_n = ST_FON;
                  pc_n    = '0;
                  fc_n    = '0;
                  led_n   = 1'b1;
               end else begin
                  pc_n = pc + PW'(1);
               end
            end
            default: begin
               state_n = ST_IDLE;
               pc_n    = '0;
               fc_n    = '0;
               led_n   = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: shared prescaler tick, sync realign, CH channel FSMs.
module led_blink_multi
   import led_blink_pkg::*;
#(
   parameter int unsigned CH         = 4,
   parameter int unsigned TICK_DIV   = 100000,
   parameter int unsigned HALF_BASE  = 500,
   parameter int unsigned BURST_N    = 3,
   parameter int unsigned GAP_HALVES = 4
) (
   input  logic              clk,
   input  logic              R,
   input  logic [2*CH-1:0]   mode,
   input  logic [2*CH-1:0]   rate,
   input  logic              sync,
   output logic              tick,
   output logic [CH-1:0]     LED
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] count;

   // Prescaler: wraps at TICK_DIV-1, tick fires the cycle after; sync realigns
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (sync) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= (count == CW'(TICK_DIV - 1));
         count <= (count == CW'(TICK_DIV - 1)) ? '0 : count + CW'(1);
      end
   end

   // One independent FSM per channel
   for (genvar i = 0; i < int'(CH); i++) begin : g_chan
      led_chan_fsm #(
         .HALF_BASE  (HALF_BASE),
         .BURST_N    (BURST_N),
         .GAP_HALVES (GAP_HALVES)
      ) u_chan (
         .clk  (clk),
         .rst  (R),
         .tick (tick),
         .sync (sync),
         .mode (mode[2*i +: 2]),
         .rate (rate[2*i +: 2]),
         .led  (LED[i])
      );
   end

endmodule
